coin_pulse_gen: RTL and testbench



---
 rtl/coin_pulse_gen_if.sv | 42 ++++
 rtl/coin_pulse_gen.sv | 156 +++++++++++++++
 tb/tb_coin_pulse_gen.sv | 275 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/coin_pulse_gen_if.sv
// -----------------------------------------------------------------------------
// coin_pulse_gen_if
//   Signal bundle between the coin conditioner and the logic that feeds it and
//   consumes its pulses.
//   master : drives coin_raw / credit_light_n, observes the conditioner outputs
//   slave  : the conditioner itself
//   Signals:
//     coin_raw       raw coin button, asynchronous to the system clock
//     credit_light_n core credit lamp, 1 = no credit left (coin allowed)
//     coin_sw        coin-switch pulse to the core
//     pending        queued coins not yet issued
//     busy           high while a pulse or its guard gap is in progress
//     dropped        one-cycle strobe when a coin arrives with the queue full
// -----------------------------------------------------------------------------
interface coin_pulse_gen_if #(
   parameter int unsigned QW = 3
);
   logic          coin_raw;
   logic          credit_light_n;
   logic          coin_sw;
   logic [QW-1:0] pending;
   logic          busy;
   logic          dropped;

   modport master (
      output coin_raw,
      output credit_light_n,
      input  coin_sw,
      input  pending,
      input  busy,
      input  dropped
   );

   modport slave (
      input  coin_raw,
      input  credit_light_n,
      output coin_sw,
      output pending,
      output busy,
      output dropped
   );
endinterface

// File: rtl/coin_pulse_gen.sv
// -----------------------------------------------------------------------------
// coin_pulse_gen
//   Conditions the raw player coin button for the core's COIN_SW input:
//   two-flop synchroniser, debounce, rising-edge event, saturating pending-coin
//   queue, and an IDLE/PULSE/GAP sequencer that issues one fixed-width pulse
//   per queued coin, only while the core shows no credit.
//   Ports:
//     clk_sys  system clock, single domain
//     reset    synchronous, active-high
//     bus      coin_pulse_gen_if.slave (coin_raw, credit_light_n in;
//              coin_sw, pending, busy, dropped out)
// -----------------------------------------------------------------------------
module coin_pulse_gen #(
   parameter int unsigned DEBOUNCE_CNT = 57272,
   parameter int unsigned PULSE_CNT    = 600000,
   parameter int unsigned GAP_CNT      = 600000,
   parameter int unsigned QUEUE_MAX    = 7,
   parameter int unsigned QW           = 3
) (
   input  logic             clk_sys,
   input  logic             reset,
   coin_pulse_gen_if.slave  bus
);

   localparam int unsigned DBW = (DEBOUNCE_CNT > 1) ? $clog2(DEBOUNCE_CNT) : 1;
   localparam int unsigned PW  = (PULSE_CNT > 1)    ? $clog2(PULSE_CNT)    : 1;
   localparam int unsigned GW  = (GAP_CNT > 1)      ? $clog2(GAP_CNT)      : 1;
   localparam int unsigned TW  = (PW > GW) ? PW : GW;

   localparam logic [DBW-1:0] DB_LAST = DBW'(DEBOUNCE_CNT - 1);
   localparam logic [TW-1:0]  P_LAST  = TW'(PULSE_CNT - 1);
   // The IDLE cycle that follows GAP is itself low, so GAP lasts one cycle
   // less than GAP_CNT; this makes the low time between back-to-back pulses
   // exactly GAP_CNT. GAP always lasts at least one cycle.
   localparam logic [TW-1:0]  G_LAST  = TW'((GAP_CNT > 1) ? GAP_CNT - 2 : 0);
   localparam logic [QW-1:0]  Q_MAX   = QW'(QUEUE_MAX);

   typedef enum logic [1:0] {
      IDLE,
      PULSE,
      GAP
   } state_t;

   state_t         state_q, state_d;
   logic           s1_q, s2_q;
   logic           deb_q, deb_d;
   logic           deb_dly_q;
   logic [DBW-1:0] dbc_q, dbc_d;
   logic [TW-1:0]  tmr_q, tmr_d;
   logic [QW-1:0]  pend_q, pend_d;
   logic           coin_sw_q, busy_q;
   logic           dropped_q, dropped_d;
   logic           coin_evt;
   logic           leave_idle;

   // Debounce: count consecutive mismatch cycles; any match clears the count.
   always_comb begin
      dbc_d = '0;
      deb_d = deb_q;
      if (s2_q != deb_q) begin
         if (dbc_q == DB_LAST) begin
            deb_d = s2_q;
         end else begin
            dbc_d = dbc_q + DBW'(1);
         end
      end
   end

   // Only a rising edge of the debounced level is a coin.
   assign coin_evt = deb_q & ~deb_dly_q;

   // Sequencer next state and timer.
   always_comb begin
      state_d    = state_q;
      tmr_d      = tmr_q;
      leave_idle = 1'b0;
      case (state_q)
         IDLE: begin
            tmr_d = '0;
            if ((pend_q != '0) && bus.credit_light_n) begin
               state_d    = PULSE;
               leave_idle = 1'b1;
            end
         end
         PULSE: begin
            if (tmr_q == P_LAST) begin
               state_d = GAP;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         GAP: begin
            if (tmr_q == G_LAST) begin
               state_d = IDLE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + TW'(1);
            end
         end
         default: begin
            state_d = IDLE;
            tmr_d   = '0;
         end
      endcase
   end

   // Saturating queue; a simultaneous arrival and issue cancel out.
   always_comb begin
      pend_d    = pend_q;
      dropped_d = 1'b0;
      if (coin_evt && !leave_idle) begin
         if (pend_q == Q_MAX) begin
            dropped_d = 1'b1;
         end else begin
            pend_d = pend_q + QW'(1);
         end
      end else if (leave_idle && !coin_evt) begin
         pend_d = pend_q - QW'(1);
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         s1_q      <= 1'b0;
         s2_q      <= 1'b0;
         deb_q     <= 1'b0;
         deb_dly_q <= 1'b0;
         dbc_q     <= '0;
         state_q   <= IDLE;
         tmr_q     <= '0;
         pend_q    <= '0;
         coin_sw_q <= 1'b0;
         busy_q    <= 1'b0;
         dropped_q <= 1'b0;
      end else begin
         s1_q      <= bus.coin_raw;
         s2_q      <= s1_q;
         deb_q     <= deb_d;
         deb_dly_q <= deb_q;
         dbc_q     <= dbc_d;
         state_q   <= state_d;
         tmr_q     <= tmr_d;
         pend_q    <= pend_d;
         coin_sw_q <= (state_d == PULSE);
         busy_q    <= (state_d != IDLE);
         dropped_q <= dropped_d;
      end
   end

   assign bus.coin_sw = coin_sw_q;
   assign bus.busy    = busy_q;
   assign bus.pending = pend_q;
   assign bus.dropped = dropped_q;

endmodule

// File: tb/tb_coin_pulse_gen.sv
// -----------------------------------------------------------------------------
// tb_coin_pulse_gen
//   Self-checking bench for coin_pulse_gen with small parameters
//   (DEBOUNCE 4, PULSE 10, GAP 5, QUEUE_MAX 3, QW 2). A timeline model derived
//   from the coin rules predicts every output each cycle; fixed vector tables
//   and hand sequences pin down the documented corner cases.
// -----------------------------------------------------------------------------
module tb_coin_pulse_gen;

   localparam int D    = 4;
   localparam int P    = 10;
   localparam int G    = 5;
   localparam int QMAX = 3;

   logic clk_sys;
   logic reset;

   coin_pulse_gen_if #(.QW(2)) bus ();

   coin_pulse_gen #(
      .DEBOUNCE_CNT (D),
      .PULSE_CNT    (P),
      .GAP_CNT      (G),
      .QUEUE_MAX    (QMAX),
      .QW           (2)
   ) dut (
      .clk_sys (clk_sys),
      .reset   (reset),
      .bus     (bus)
   );

   initial clk_sys = 1'b0;
   always #5 clk_sys = ~clk_sys;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   // Model state: sampled-input history and event timestamps.
   logic m_s1;
   logic m_hist[$];
   logic m_deb;
   logic m_rose;
   logic m_drop;
   int   m_last_chg;
   int   m_pend;
   int   m_pulse_end;
   int   m_busy_end;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // One clock edge of the reference model. The debounced level flips once the
   // last D synchronised samples all differ from it and no change or reset
   // happened inside that window. A coin issues when the sequencer has been
   // idle since the previous edge; it then owns P high cycles and the low
   // stretch that follows, so the next coin can issue no sooner than P+G edges.
   task automatic model_edge(input logic raw, input logic cln, input logic rst);
      bit flip, evt, iss;
      if (rst) begin
         m_s1 = 1'b0;
         m_hist.push_back(1'b0);
         m_deb = 1'b0;
         m_rose = 1'b0;
         m_drop = 1'b0;
         m_last_chg = cyc;
         m_pend = 0;
         m_pulse_end = -1000;
         m_busy_end = -1000;
      end else begin
         flip = 1'b0;
         if (m_hist.size() >= D && (cyc - m_last_chg) >= D) begin
            flip = 1'b1;
            for (int k = 0; k < D; k++)
               if (m_hist[m_hist.size() - 1 - k] == m_deb) flip = 1'b0;
         end
         evt = m_rose;
         iss = (cyc - 1 > m_busy_end) && (m_pend > 0) && cln;
         m_drop = 1'b0;
         if (evt && !iss) begin
            if (m_pend == QMAX) m_drop = 1'b1;
            else m_pend++;
         end else if (iss && !evt) begin
            m_pend--;
         end
         if (iss) begin
            m_pulse_end = cyc + P - 1;
            m_busy_end  = cyc + P + ((G > 1) ? G - 1 : 1) - 1;
         end
         m_hist.push_back(m_s1);
         m_s1 = raw;
         m_rose = flip && !m_deb;
         if (flip) begin
            m_deb = ~m_deb;
            m_last_chg = cyc;
         end
      end
      while (m_hist.size() > D) void'(m_hist.pop_front());
   endtask

   task automatic step(input logic raw, input logic cln, input logic rst);
      int e_sw, e_busy;
      bus.coin_raw       = raw;
      bus.credit_light_n = cln;
      reset              = rst;
      @(posedge clk_sys);
      model_edge(raw, cln, rst);
      e_sw   = (cyc <= m_pulse_end) ? 1 : 0;
      e_busy = (cyc <= m_busy_end) ? 1 : 0;
      #1;
      chk("model_coin_sw", int'(bus.coin_sw), e_sw);
      chk("model_busy",    int'(bus.busy),    e_busy);
      chk("model_pending", int'(bus.pending), m_pend);
      chk("model_dropped", int'(bus.dropped), int'(m_drop));
      cyc++;
   endtask

   task automatic do_reset(input logic cln);
      step(1'b0, cln, 1'b1);
      step(1'b0, cln, 1'b1);
   endtask

   // Clean press: long enough to debounce both edges.
   task automatic press(input logic cln);
      for (int i = 0; i < 16; i++) step((i < 8) ? 1'b1 : 1'b0, cln, 1'b0);
   endtask

   typedef struct {
      logic raw;
      logic cln;
      int   n;
      int   sw;
      int   pend;
      int   busy;
      int   drop;
   } vec_t;

   vec_t tbl[$];

   initial begin
      logic swtr[40];
      int   pdtr[40];
      int   drop_cnt, drop_run, drop_max, sw_seen;
      logic raw_r, cln_r;
      int   raw_len, cln_len;

      bus.coin_raw = 1'b0;
      bus.credit_light_n = 1'b1;
      reset = 1'b1;
      m_hist.delete();
      m_s1 = 1'b0; m_deb = 1'b0; m_rose = 1'b0; m_drop = 1'b0;
      m_last_chg = 0; m_pend = 0; m_pulse_end = -1000; m_busy_end = -1000;

      // Reset state
      do_reset(1'b1);
      chk("rst_coin_sw", int'(bus.coin_sw), 0);
      chk("rst_pending", int'(bus.pending), 0);
      chk("rst_busy",    int'(bus.busy),    0);
      chk("rst_dropped", int'(bus.dropped), 0);

      // Single coin from edge 0, then a too-short glitch.
      tbl.push_back('{1'b1, 1'b1, 6,  0, 0, 0, 0});
      tbl.push_back('{1'b1, 1'b1, 1,  0, 1, 0, 0});
      tbl.push_back('{1'b1, 1'b1, 1,  1, 0, 1, 0});
      tbl.push_back('{1'b1, 1'b1, 9,  1, 0, 1, 0});
      tbl.push_back('{1'b1, 1'b1, 1,  0, 0, 1, 0});
      tbl.push_back('{1'b1, 1'b1, 3,  0, 0, 1, 0});
      tbl.push_back('{1'b1, 1'b1, 1,  0, 0, 0, 0});
      tbl.push_back('{1'b0, 1'b1, 12, 0, 0, 0, 0});
      tbl.push_back('{1'b1, 1'b1, 3,  0, 0, 0, 0});
      tbl.push_back('{1'b0, 1'b1, 12, 0, 0, 0, 0});
      foreach (tbl[r]) begin
         for (int i = 0; i < tbl[r].n; i++) begin
            step(tbl[r].raw, tbl[r].cln, 1'b0);
            chk($sformatf("tbl%0d_coin_sw", r), int'(bus.coin_sw), tbl[r].sw);
            chk($sformatf("tbl%0d_pending", r), int'(bus.pending), tbl[r].pend);
            chk($sformatf("tbl%0d_busy", r),    int'(bus.busy),    tbl[r].busy);
            chk($sformatf("tbl%0d_dropped", r), int'(bus.dropped), tbl[r].drop);
         end
      end

      // Queue during play, then release with credit lamp off.
      do_reset(1'b0);
      sw_seen = 0;
      for (int k = 0; k < 2; k++) begin
         for (int i = 0; i < 16; i++) begin
            step((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (bus.coin_sw) sw_seen++;
         end
      end
      chk("queue_pending2", int'(bus.pending), 2);
      chk("queue_no_pulse", sw_seen, 0);
      for (int i = 0; i < 40; i++) begin
         step(1'b0, 1'b1, 1'b0);
         swtr[i] = bus.coin_sw;
         pdtr[i] = int'(bus.pending);
      end
      for (int i = 0; i < 40; i++)
         chk($sformatf("queue_sw[%0d]", i), int'(swtr[i]),
             ((i < 10) || (i >= 15 && i < 25)) ? 1 : 0);
      chk("queue_pend_first",  pdtr[0],  1);
      chk("queue_pend_before", pdtr[14], 1);
      chk("queue_pend_second", pdtr[15], 0);

      // Overflow: five presses into a queue of three.
      do_reset(1'b0);
      drop_cnt = 0; drop_run = 0; drop_max = 0;
      for (int k = 0; k < 5; k++) begin
         for (int i = 0; i < 16; i++) begin
            step((i < 8) ? 1'b1 : 1'b0, 1'b0, 1'b0);
            if (bus.dropped) begin
               drop_cnt++;
               drop_run++;
               if (drop_run > drop_max) drop_max = drop_run;
            end else begin
               drop_run = 0;
            end
         end
      end
      chk("ovf_pending",   int'(bus.pending), 3);
      chk("ovf_drop_cnt",  drop_cnt, 2);
      chk("ovf_drop_width", drop_max, 1);

      // Full queue: lamp goes off on the very edge a new coin event lands.
      for (int i = 0; i < 16; i++) begin
         step((i < 8) ? 1'b1 : 1'b0, (i >= 6) ? 1'b1 : 1'b0, 1'b0);
         if (i == 6) begin
            chk("simul_pending", int'(bus.pending), 3);
            chk("simul_dropped", int'(bus.dropped), 0);
            chk("simul_coin_sw", int'(bus.coin_sw), 1);
         end
      end

      // Reset at pulse cycle 4.
      do_reset(1'b1);
      for (int i = 0; i < 12; i++) begin
         step((i < 8) ? 1'b1 : 1'b0, 1'b1, (i == 11) ? 1'b1 : 1'b0);
         if (i == 10) chk("rstmid_pulse_on", int'(bus.coin_sw), 1);
      end
      chk("rstmid_coin_sw", int'(bus.coin_sw), 0);
      chk("rstmid_pending", int'(bus.pending), 0);
      chk("rstmid_busy",    int'(bus.busy),    0);
      sw_seen = 0;
      for (int i = 0; i < 30; i++) begin
         step(1'b0, 1'b1, 1'b0);
         if (bus.coin_sw) sw_seen++;
      end
      chk("rstmid_no_resume", sw_seen, 0);

      // Randomised traffic against the model.
      raw_r = 1'b0; cln_r = 1'b1; raw_len = 0; cln_len = 0;
      for (int i = 0; i < 3000; i++) begin
         if (raw_len == 0) begin
            raw_r = ~raw_r;
            raw_len = $urandom_range(1, 12);
         end
         if (cln_len == 0) begin
            cln_r = ~cln_r;
            cln_len = $urandom_range(1, 60);
         end
         raw_len--;
         cln_len--;
         step(raw_r, cln_r, ($urandom_range(0, 399) == 0) ? 1'b1 : 1'b0);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
